// File: rtl/aska_spi_master.sv
// SPI mode-0 master that shifts one 128-bit ASKA configuration frame (conf0, conf1, ele1, ele2)
// MSB first inside a single chip-select burst. SPI_Clk comes from clk through an integer divider.
module aska_spi_master #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_SETUP    = 4,
    parameter int unsigned CS_HOLD     = 4,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] conf0,
    input  logic [31:0] conf1,
    input  logic [31:0] ele1,
    input  logic [31:0] ele2,
    output logic        busy,
    output logic        done,
    output logic        SPI_CS,
    output logic        SPI_Clk,
    output logic        SPI_MOSI
);

    localparam int unsigned MaxA = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int unsigned MaxB = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MaxP = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW = $clog2(MaxP) + 1;

    localparam logic [CntW-1:0] HalfLd  = CntW'(HALF_PERIOD);
    localparam logic [CntW-1:0] SetupLd = CntW'(CS_SETUP);
    localparam logic [CntW-1:0] HoldLd  = CntW'(CS_HOLD);
    localparam logic [CntW-1:0] GapLd   = CntW'(CS_GAP);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSckHi,
        StSckLo,
        StHold,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    sreg_q, sreg_d;
    logic [6:0]      bit_q, bit_d;
    logic            last_q, last_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        last_d  = last_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = {conf0, conf1, ele1, ele2};
                    bit_d   = '0;
                    last_d  = 1'b0;
                    cnt_d   = SetupLd;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == CntOne) begin
                    sclk_d  = 1'b1;
                    cnt_d   = HalfLd;
                    state_d = StSckHi;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StSckHi: begin
                if (cnt_q == CntOne) begin
                    sclk_d  = 1'b0;
                    cnt_d   = HalfLd;
                    state_d = StSckLo;
                    // MOSI is sreg[127]; after the 128th bit a zero has been shifted into place
                    sreg_d  = {sreg_q[126:0], 1'b0};
                    if (bit_q != 7'd127) begin
                        bit_d = bit_q + 7'd1;
                    end else begin
                        last_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StSckLo: begin
                if (cnt_q == CntOne) begin
                    if (!last_q) begin
                        sclk_d  = 1'b1;
                        cnt_d   = HalfLd;
                        state_d = StSckHi;
                    end else begin
                        cnt_d   = HoldLd;
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHold: begin
                if (cnt_q == CntOne) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = GapLd;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                if (cnt_q == CntOne) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_CS   = cs_q;
    assign SPI_Clk  = sclk_q;
    assign SPI_MOSI = sreg_q[127];

endmodule

// File: tb/tb_aska_spi_master.sv
// Bench for aska_spi_master: a mode-0 slave model captures each CS frame and its timing, and
// frames are scored against words queued when start is driven.
module tb_aska_spi_master;

    localparam int HP = 4;
    localparam int SU = 4;
    localparam int HO = 4;
    localparam int GA = 4;
    localparam int CsLow = SU + 256 * HP + HO;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] conf0 = '0, conf1 = '0, ele1 = '0, ele2 = '0;
    logic        busy, done, SPI_CS, SPI_Clk, SPI_MOSI;

    always #5 clk = ~clk;

    aska_spi_master #(
        .HALF_PERIOD(HP),
        .CS_SETUP   (SU),
        .CS_HOLD    (HO),
        .CS_GAP     (GA)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .conf0   (conf0),
        .conf1   (conf1),
        .ele1    (ele1),
        .ele2    (ele2),
        .busy    (busy),
        .done    (done),
        .SPI_CS  (SPI_CS),
        .SPI_Clk (SPI_Clk),
        .SPI_MOSI(SPI_MOSI)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    int           obs_n[$];

    // Slave/timing monitor, sampling on the falling clk edge
    int           cyc = 0;
    logic         prev_cs = 1'b1, prev_clk = 1'b0, prev_busy = 1'b0;
    logic [127:0] cap = '0;
    int           nbits = 0;
    int           done_cnt = 0, frames_started = 0;
    int           cs_fall_cyc = 0, cs_rise_cyc = 0, cs_low_len = 0, cs_high_len = 0;
    int           first_rise_cyc = 0, last_edge_cyc = 0, min_ph = 0, max_ph = 0;
    int           busy_rise_cyc = 0, busy_fall_cyc = 0, busy_len = 0, fall_after_busy = 0;
    logic         first_seen = 1'b0, done_at_rise = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            nbits = 0;
        end else begin
            if (done) done_cnt++;
            if (!prev_busy && busy) busy_rise_cyc = cyc;
            if (prev_busy && !busy) begin
                busy_fall_cyc = cyc;
                busy_len      = cyc - busy_rise_cyc;
            end
            if (prev_cs && !SPI_CS) begin
                cs_fall_cyc     = cyc;
                cs_high_len     = cyc - cs_rise_cyc;
                fall_after_busy = cyc - busy_fall_cyc;
                frames_started++;
                nbits      = 0;
                first_seen = 1'b0;
                min_ph     = 1 << 30;
                max_ph     = 0;
            end
            if (!SPI_CS && (SPI_Clk != prev_clk)) begin
                if (SPI_Clk && !first_seen) begin
                    first_seen     = 1'b1;
                    first_rise_cyc = cyc;
                end else begin
                    if (cyc - last_edge_cyc < min_ph) min_ph = cyc - last_edge_cyc;
                    if (cyc - last_edge_cyc > max_ph) max_ph = cyc - last_edge_cyc;
                end
                last_edge_cyc = cyc;
                if (SPI_Clk) begin
                    cap = {cap[126:0], SPI_MOSI};
                    nbits++;
                end
            end
            if (!prev_cs && SPI_CS) begin
                cs_rise_cyc  = cyc;
                cs_low_len   = cyc - cs_fall_cyc;
                done_at_rise = done;
                obs_q.push_back(cap);
                obs_n.push_back(nbits);
            end
        end
        prev_cs   = SPI_CS;
        prev_clk  = SPI_Clk;
        prev_busy = busy;
    end

    task automatic send_frame(input logic [31:0] w0, w1, w2, w3);
        conf0 = w0; conf1 = w1; ele1 = w2; ele2 = w3;
        exp_q.push_back({w0, w1, w2, w3});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames_done(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done_cnt >= target && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: done_cnt=%0d required %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        int d0;
        logic [127:0] junk;
        repeat (3) @(negedge clk);
        checks += 5;
        if (SPI_CS !== 1'b1)   begin errors++; $display("FAIL rst_cs got=%b want=1", SPI_CS); end
        if (SPI_Clk !== 1'b0)  begin errors++; $display("FAIL rst_clk got=%b want=0", SPI_Clk); end
        if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got=%b want=0", SPI_MOSI); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        reset = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 200 && !SPI_Clk; i++) @(negedge clk);
        checks++;
        if (SPI_Clk !== 1'b1) begin errors++; $display("FAIL rst_reach_hi got=%b want=1", SPI_Clk); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 4;
        if (SPI_CS !== 1'b1)   begin errors++; $display("FAIL mid_rst_cs got=%b want=1", SPI_CS); end
        if (SPI_Clk !== 1'b0)  begin errors++; $display("FAIL mid_rst_clk got=%b want=0", SPI_Clk); end
        if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL mid_rst_mosi got=%b want=0", SPI_MOSI); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks += 2;
        if (done_cnt != d0) begin errors++; $display("FAIL mid_rst_done got=%0d want=%0d", done_cnt, d0); end
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL mid_rst_frames got=%0d want=0", obs_q.size());
        end
        while (exp_q.size() > 0) junk = exp_q.pop_front();
    endtask

    task automatic test_frame();
        int d0 = done_cnt;
        logic [127:0] e, o;
        int n;
        send_frame(32'hA5000FFF, 32'h0012C3E8, 32'h00000001, 32'h80000000);
        wait_frames_done(d0 + 1, "frame");
        checks += 5;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL frame_count got=%0d want=1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = obs_n.pop_front();
            if (o !== e) begin errors++; $display("FAIL frame_data got=%h want=%h", o, e); end
            if (n != 128) begin errors++; $display("FAIL frame_bits got=%0d want=128", n); end
        end
        if (done_cnt != d0 + 1) begin
            errors++; $display("FAIL frame_done got=%0d want=%0d", done_cnt - d0, 1);
        end
        if (done_at_rise !== 1'b1) begin
            errors++; $display("FAIL done_with_cs got=%b want=1", done_at_rise);
        end
        if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL idle_mosi got=%b want=0", SPI_MOSI); end
    endtask

    task automatic test_timing();
        int d0 = done_cnt;
        logic [127:0] e, o;
        int n;
        send_frame($urandom, $urandom, $urandom, $urandom);
        wait_frames_done(d0 + 1, "timing");
        checks += 6;
        if (cs_low_len != CsLow) begin
            errors++; $display("FAIL cs_low got=%0d want=%0d", cs_low_len, CsLow);
        end
        // First SPI_Clk rise lands CS_SETUP clk edges after the CS fall edge
        if (first_rise_cyc - cs_fall_cyc != SU) begin
            errors++; $display("FAIL setup got=%0d want=%0d", first_rise_cyc - cs_fall_cyc, SU);
        end
        if (min_ph != HP) begin errors++; $display("FAIL phase_min got=%0d want=%0d", min_ph, HP); end
        if (max_ph != HP) begin errors++; $display("FAIL phase_max got=%0d want=%0d", max_ph, HP); end
        if (busy_len != CsLow + GA) begin
            errors++; $display("FAIL busy_len got=%0d want=%0d", busy_len, CsLow + GA);
        end
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL timing_count got=%0d want=1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = obs_n.pop_front();
            checks += 2;
            if (o !== e) begin errors++; $display("FAIL timing_data got=%h want=%h", o, e); end
            if (n != 128) begin errors++; $display("FAIL timing_bits got=%0d want=128", n); end
        end
    endtask

    task automatic test_snapshot();
        int d0 = done_cnt;
        int f0 = frames_started;
        logic [127:0] e, o;
        int n;
        send_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF00DCAFE);
        repeat (200) @(negedge clk);
        conf0 = 32'hDEADBEEF; conf1 = 32'h00000000; ele1 = 32'hFFFFFFFF; ele2 = 32'h55555555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frames_done(d0 + 1, "snapshot");
        repeat (20) @(negedge clk);
        checks += 2;
        if (frames_started != f0 + 1) begin
            errors++; $display("FAIL snap_frames got=%0d want=%0d", frames_started - f0, 1);
        end
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL snap_count got=%0d want=1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = obs_n.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL snap_data got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int f0 = frames_started;
        bit ok = 1'b0;
        logic [127:0] e, o;
        int n;
        conf0 = 32'hC0FFEE00; conf1 = 32'h11223344; ele1 = 32'h0000FFFF; ele2 = 32'h7FFFFFFE;
        exp_q.push_back({conf0, conf1, ele1, ele2});
        exp_q.push_back({conf0, conf1, ele1, ele2});
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frames_started >= f0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_second timeout frames=%0d", frames_started - f0); end
        if (fall_after_busy != 1) begin
            errors++; $display("FAIL b2b_restart got=%0d want=1", fall_after_busy);
        end
        if (cs_high_len < GA + 1) begin
            errors++; $display("FAIL b2b_cs_high got=%0d want>=%0d", cs_high_len, GA + 1);
        end
        wait_frames_done(d0 + 2, "b2b");
        repeat (10) @(negedge clk);
        checks += 2;
        if (frames_started != f0 + 2) begin
            errors++; $display("FAIL b2b_frames got=%0d want=2", frames_started - f0);
        end
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL b2b_count got=%0d want=2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n = obs_n.pop_front();
                checks++;
                if (o !== e || n != 128) begin
                    errors++;
                    $display("FAIL b2b_data%0d got=%h/%0d want=%h/128", k, o, n, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timing();
        test_snapshot();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
